// File: rtl/poly_voice_allocator.sv
// poly_voice_allocator
// Sixteen-voice note allocator feeding the frequency lookup stage.
// Events arrive one at a time on a valid/ready handshake. Each event is
// resolved by scanning one voice per clock (16 cycles) and then applied in
// a single commit cycle. A note-on goes to a voice already playing that
// note, else the lowest free voice, else the oldest voice, which is stolen.
// A note-off releases every gated voice playing that note.
//
// Optional build: define POLY_VOICE_ALLOCATOR_SUSTAIN_EN to add a sustain
// pedal input. While the pedal is down, note-offs mark voices as held
// instead of releasing them. Lifting the pedal in IDLE releases all held
// voices in one cycle.
module poly_voice_allocator #(
  parameter int AGE_WIDTH = 8,
  parameter int NOTE_MAX  = 107
) (
  input  logic        clk,
  input  logic        reset,
`ifdef POLY_VOICE_ALLOCATOR_SUSTAIN_EN
  input  logic        sustain,
`endif
  input  logic        event_valid,
  output logic        event_ready,
  input  logic        event_on,
  input  logic [6:0]  event_note,
  output logic [6:0]  note1,
  output logic [6:0]  note2,
  output logic [6:0]  note3,
  output logic [6:0]  note4,
  output logic [6:0]  note5,
  output logic [6:0]  note6,
  output logic [6:0]  note7,
  output logic [6:0]  note8,
  output logic [6:0]  note9,
  output logic [6:0]  note10,
  output logic [6:0]  note11,
  output logic [6:0]  note12,
  output logic [6:0]  note13,
  output logic [6:0]  note14,
  output logic [6:0]  note15,
  output logic [6:0]  note16,
  output logic [15:0] gate,
  output logic        update,
  output logic        stolen
);

  localparam int         NV         = 16;
  localparam logic [6:0] NOTE_MAX_C = 7'(NOTE_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_COMMIT
  } state_e;

  typedef logic [AGE_WIDTH-1:0] age_t;

  // Control and scan bookkeeping
  state_e      state_q;
  logic [3:0]  idx_q;
  logic        ev_on_q;
  logic [6:0]  ev_note_q;
  logic [15:0] match_mask_q;
  logic        match_vld_q;
  logic [3:0]  match_idx_q;
  logic        free_vld_q;
  logic [3:0]  free_idx_q;
  logic [3:0]  old_idx_q;
  age_t        old_age_q;
  logic        ready_q;
  logic        update_q;
  logic        stolen_q;

  // Per-voice state
  logic [6:0]  note_q [NV];
  logic [6:0]  note_d [NV];
  age_t        age_q  [NV];
  age_t        age_d  [NV];
  logic [15:0] gate_q;
  logic [15:0] gate_d;

`ifdef POLY_VOICE_ALLOCATOR_SUSTAIN_EN
  logic [15:0] held_q;
  logic [15:0] held_d;
  logic        sus_q;
  logic        sus_fall;
`endif

  // Combinational helpers
  logic [6:0]  cur_note;
  logic        cur_gate;
  age_t        cur_age;
  logic        cur_hit;
  logic        xfer;
  logic        note_ok;
  logic        do_on;
  logic        do_off;
  logic [3:0]  tgt_idx;
  logic        steal;
  logic        changed;

`ifdef POLY_VOICE_ALLOCATOR_SUSTAIN_EN
  // The pedal level is tracked only in IDLE, so a release that happens
  // mid-event is acted on at the first IDLE cycle. That cycle is spent
  // releasing held voices, so no event is accepted during it.
  assign sus_fall    = (state_q == S_IDLE) && sus_q && !sustain;
  assign event_ready = ready_q && !sus_fall;
`else
  assign event_ready = ready_q;
`endif

  assign xfer    = event_valid && event_ready;
  assign note_ok = (ev_note_q <= NOTE_MAX_C);
  assign do_on   = note_ok && ev_on_q;
  assign do_off  = note_ok && !ev_on_q;

  // Read the single voice slot currently being scanned
  always_comb begin
    cur_note = note_q[idx_q];
    cur_gate = gate_q[idx_q];
    cur_age  = age_q[idx_q];
    cur_hit  = cur_gate && (cur_note == ev_note_q);
  end

  // Note-on target: retrigger, else free voice, else steal the oldest
  always_comb begin
    steal   = 1'b0;
    tgt_idx = old_idx_q;
    if (match_vld_q) begin
      tgt_idx = match_idx_q;
    end else if (free_vld_q) begin
      tgt_idx = free_idx_q;
    end else begin
      steal = 1'b1;
    end
  end

  // Next voice state for the commit cycle (and the sustain release cycle)
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    for (int i = 0; i < NV; i++) begin
      note_d[i] = note_q[i];
      age_d[i]  = age_q[i];
    end
    gate_d  = gate_q;
    changed = 1'b0;
`ifdef POLY_VOICE_ALLOCATOR_SUSTAIN_EN
    held_d  = held_q;
`endif
    if (state_q == S_COMMIT && do_on) begin
      for (int i = 0; i < NV; i++) begin
        if (gate_q[i] && (4'(i) != tgt_idx) && (age_q[i] != '1)) begin
          age_d[i] = age_q[i] + age_t'(1);
        end
      end
      note_d[tgt_idx] = ev_note_q;
      age_d[tgt_idx]  = '0;
      gate_d[tgt_idx] = 1'b1;
`ifdef POLY_VOICE_ALLOCATOR_SUSTAIN_EN
      held_d[tgt_idx] = 1'b0;
`endif
      changed = 1'b1;
    end else if (state_q == S_COMMIT && do_off) begin
`ifdef POLY_VOICE_ALLOCATOR_SUSTAIN_EN
      if (sus_q) begin
        held_d = held_q | match_mask_q;
      end else begin
        gate_d  = gate_q & ~match_mask_q;
        held_d  = held_q & ~match_mask_q;
        changed = |match_mask_q;
      end
`else
      // Note values stay put so the release tail keeps its pitch
      gate_d  = gate_q & ~match_mask_q;
      changed = |match_mask_q;
`endif
    end
`ifdef POLY_VOICE_ALLOCATOR_SUSTAIN_EN
    else if (sus_fall) begin
      gate_d  = gate_q & ~held_q;
      held_d  = '0;
      changed = |(gate_q & held_q);
    end
`endif
  end

  // Event FSM: accept, scan 16 voices, commit; registered strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      ev_on_q      <= 1'b0;
      ev_note_q    <= '0;
      match_mask_q <= '0;
      match_vld_q  <= 1'b0;
      match_idx_q  <= '0;
      free_vld_q   <= 1'b0;
      free_idx_q   <= '0;
      old_idx_q    <= '0;
      old_age_q    <= '0;
      ready_q      <= 1'b0;
      update_q     <= 1'b0;
      stolen_q     <= 1'b0;
`ifdef POLY_VOICE_ALLOCATOR_SUSTAIN_EN
      sus_q        <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      update_q <= changed;
      stolen_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
`ifdef POLY_VOICE_ALLOCATOR_SUSTAIN_EN
          sus_q <= sustain;
`endif
          if (xfer) begin
            ev_on_q      <= event_on;
            ev_note_q    <= event_note;
            idx_q        <= '0;
            match_mask_q <= '0;
            match_vld_q  <= 1'b0;
            free_vld_q   <= 1'b0;
            ready_q      <= 1'b0;
            state_q      <= S_SCAN;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_SCAN: begin
          if (cur_hit) begin
            match_mask_q[idx_q] <= 1'b1;
            if (!match_vld_q) begin
              match_vld_q <= 1'b1;
              match_idx_q <= idx_q;
            end
          end
          if (!cur_gate && !free_vld_q) begin
            free_vld_q <= 1'b1;
            free_idx_q <= idx_q;
          end
          // Strict compare keeps the lowest index on equal ages
          if (idx_q == 4'd0 || cur_age > old_age_q) begin
            old_idx_q <= idx_q;
            old_age_q <= cur_age;
          end
          if (idx_q == 4'd15) begin
            state_q <= S_COMMIT;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        S_COMMIT: begin
          stolen_q <= do_on && steal;
          ready_q  <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Voice state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the note and age arrays are reset as well, because the note
      // outputs are consumed directly downstream and must start at zero.
      for (int i = 0; i < NV; i++) begin
        note_q[i] <= '0;
        age_q[i]  <= '0;
      end
      gate_q <= '0;
`ifdef POLY_VOICE_ALLOCATOR_SUSTAIN_EN
      held_q <= '0;
`endif
    end else begin
      for (int i = 0; i < NV; i++) begin
        note_q[i] <= note_d[i];
        age_q[i]  <= age_d[i];
      end
      gate_q <= gate_d;
`ifdef POLY_VOICE_ALLOCATOR_SUSTAIN_EN
      held_q <= held_d;
`endif
    end
  end

  assign note1  = note_q[0];
  assign note2  = note_q[1];
  assign note3  = note_q[2];
  assign note4  = note_q[3];
  assign note5  = note_q[4];
  assign note6  = note_q[5];
  assign note7  = note_q[6];
  assign note8  = note_q[7];
  assign note9  = note_q[8];
  assign note10 = note_q[9];
  assign note11 = note_q[10];
  assign note12 = note_q[11];
  assign note13 = note_q[12];
  assign note14 = note_q[13];
  assign note15 = note_q[14];
  assign note16 = note_q[15];
  assign gate   = gate_q;
  assign update = update_q;
  assign stolen = stolen_q;

endmodule

// File: tb/tb_poly_voice_allocator.sv
// Testbench for poly_voice_allocator: directed scenarios plus a randomized
// event stream, checked against a behavioural voice-allocation model.
module tb_poly_voice_allocator;

  localparam int AGE_MAX = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        event_valid;
  logic        event_ready;
  logic        event_on;
  logic [6:0]  event_note;
  logic [6:0]  note1, note2, note3, note4, note5, note6, note7, note8;
  logic [6:0]  note9, note10, note11, note12, note13, note14, note15, note16;
  logic [15:0] gate;
  logic        update;
  logic        stolen;
`ifdef POLY_VOICE_ALLOCATOR_SUSTAIN_EN
  logic        sustain;
`endif

  always #5 clk = ~clk;

  poly_voice_allocator dut (
    .clk         (clk),
    .reset       (reset),
`ifdef POLY_VOICE_ALLOCATOR_SUSTAIN_EN
    .sustain     (sustain),
`endif
    .event_valid (event_valid),
    .event_ready (event_ready),
    .event_on    (event_on),
    .event_note  (event_note),
    .note1       (note1),
    .note2       (note2),
    .note3       (note3),
    .note4       (note4),
    .note5       (note5),
    .note6       (note6),
    .note7       (note7),
    .note8       (note8),
    .note9       (note9),
    .note10      (note10),
    .note11      (note11),
    .note12      (note12),
    .note13      (note13),
    .note14      (note14),
    .note15      (note15),
    .note16      (note16),
    .gate        (gate),
    .update      (update),
    .stolen      (stolen)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the 16 voices
  int m_note [16];
  int m_age  [16];
  bit m_gate [16];
  bit m_held [16];
  bit m_sus;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [111:0] dut_notes();
    return {note16, note15, note14, note13, note12, note11, note10, note9,
            note8, note7, note6, note5, note4, note3, note2, note1};
  endfunction

  function automatic logic [111:0] mdl_notes();
    logic [111:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*7 +: 7] = 7'(m_note[i]);
    return v;
  endfunction

  function automatic logic [15:0] mdl_gate();
    logic [15:0] g;
    for (int i = 0; i < 16; i++) g[i] = m_gate[i];
    return g;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_note[i] = 0;
      m_age[i]  = 0;
      m_gate[i] = 1'b0;
      m_held[i] = 1'b0;
    end
  endtask

  task automatic model_apply(input bit on, input int note, output bit upd, output bit stl);
    int t;
    upd = 1'b0;
    stl = 1'b0;
    if (note > 107) return;
    if (on) begin
      t = -1;
      for (int i = 0; i < 16; i++) if (t < 0 && m_gate[i] && m_note[i] == note) t = i;
      for (int i = 0; i < 16; i++) if (t < 0 && !m_gate[i]) t = i;
      if (t < 0) begin
        t = 0;
        for (int i = 1; i < 16; i++) if (m_age[i] > m_age[t]) t = i;
        stl = 1'b1;
      end
      for (int i = 0; i < 16; i++)
        if (m_gate[i] && i != t) m_age[i] = (m_age[i] >= AGE_MAX) ? AGE_MAX : m_age[i] + 1;
      m_note[t] = note;
      m_gate[t] = 1'b1;
      m_age[t]  = 0;
      m_held[t] = 1'b0;
      upd = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (m_gate[i] && m_note[i] == note) begin
          if (m_sus) begin
            m_held[i] = 1'b1;
          end else begin
            m_gate[i] = 1'b0;
            m_held[i] = 1'b0;
            upd = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic model_release();
    for (int i = 0; i < 16; i++) begin
      if (m_held[i]) begin
        m_gate[i] = 1'b0;
        m_held[i] = 1'b0;
      end
    end
  endtask

  // Assert reset (asynchronously, from wherever we are) and check reset state
  task automatic do_reset();
    event_valid = 1'b0;
    reset = 1'b0;
    #2;
    check("rst_gate", gate, 16'h0000);
    check("rst_notes", dut_notes(), '0);
    check("rst_update", update, 1'b0);
    check("rst_stolen", stolen, 1'b0);
    check("rst_ready_low", event_ready, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready_high", event_ready, 1'b1);
    model_reset();
  endtask

  // Send one event and check the full 17-edge latency and the result.
  // With hold set, event_valid stays high during the scan carrying the
  // next event, which must not be taken before IDLE.
  task automatic do_event(input bit on, input logic [6:0] note, input bit hold,
                          input bit n_on, input logic [6:0] n_note);
    int  waited;
    int  bad;
    bit  eu, es;
    @(negedge clk);
    event_valid = 1'b1;
    event_on    = on;
    event_note  = note;
    waited = 0;
    while (!event_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", event_ready, 1'b1);
    @(posedge clk);
    #1;
    if (hold) begin
      event_valid = 1'b1;
      event_on    = n_on;
      event_note  = n_note;
    end else begin
      event_valid = 1'b0;
      event_on    = 1'($urandom);
      event_note  = 7'($urandom);
    end
    model_apply(on, int'(note), eu, es);
    bad = 0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (event_ready || update) bad++;
    end
    check("busy_quiet", bad, 0);
    @(posedge clk);
    #1;
    check("update", update, eu);
    check("stolen", stolen, es);
    check("gate", gate, mdl_gate());
    check("notes", dut_notes(), mdl_notes());
    check("ready_back", event_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         c_on, n_on, hold;
    logic [6:0] c_note, n_note;

    reset       = 1'b1;
    event_valid = 1'b0;
    event_on    = 1'b0;
    event_note  = '0;
    m_sus       = 1'b0;
`ifdef POLY_VOICE_ALLOCATOR_SUSTAIN_EN
    sustain     = 1'b0;
`endif
    #1;
    do_reset();

    // First note-on lands on voice 1
    do_event(1'b1, 7'd60, 1'b0, 1'b0, 7'd0);
    check("t1_note1", note1, 7'd60);
    check("t1_gate", gate, 16'h0001);

    // Release of a middle voice and reuse of the freed slot
    do_reset();
    do_event(1'b1, 7'd60, 1'b0, 1'b0, 7'd0);
    do_event(1'b1, 7'd62, 1'b0, 1'b0, 7'd0);
    do_event(1'b1, 7'd64, 1'b1, 1'b0, 7'd62);
    do_event(1'b0, 7'd62, 1'b0, 1'b0, 7'd0);
    check("t2_gate_off", gate, 16'h0005);
    check("t2_note2_kept", note2, 7'd62);
    do_event(1'b1, 7'd65, 1'b0, 1'b0, 7'd0);
    check("t2_gate_on", gate, 16'h0007);
    check("t2_note2_new", note2, 7'd65);

    // All voices busy: the oldest (voice 1) is stolen
    do_reset();
    for (int n = 40; n < 56; n++) do_event(1'b1, 7'(n), 1'b0, 1'b0, 7'd0);
    do_event(1'b1, 7'd70, 1'b0, 1'b0, 7'd0);
    check("t3_note1", note1, 7'd70);
    check("t3_stolen", stolen, 1'b1);
    check("t3_gate", gate, 16'hFFFF);

    // Retrigger uses the same voice; unmatched note-off is silent
    do_reset();
    do_event(1'b1, 7'd60, 1'b0, 1'b0, 7'd0);
    do_event(1'b1, 7'd60, 1'b0, 1'b0, 7'd0);
    check("t4_gate", gate, 16'h0001);
    check("t4_retrig_stolen", stolen, 1'b0);
    do_event(1'b0, 7'd61, 1'b0, 1'b0, 7'd0);
    check("t4_no_update", update, 1'b0);

    // Out-of-range note is consumed silently; then reset during a scan
    do_event(1'b1, 7'd120, 1'b1, 1'b1, 7'd50);
    check("t5_gate", gate, 16'h0001);
    check("t5_note1", note1, 7'd60);
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    do_reset();

`ifdef POLY_VOICE_ALLOCATOR_SUSTAIN_EN
    // Sustained note-off holds the gate until the pedal is lifted
    @(negedge clk);
    sustain = 1'b1;
    m_sus   = 1'b1;
    do_event(1'b1, 7'd60, 1'b0, 1'b0, 7'd0);
    do_event(1'b0, 7'd60, 1'b0, 1'b0, 7'd0);
    check("sus_gate_held", gate, 16'h0001);
    @(negedge clk);
    sustain = 1'b0;
    m_sus   = 1'b0;
    #1;
    check("sus_ready_low", event_ready, 1'b0);
    @(posedge clk);
    #1;
    model_release();
    check("sus_update", update, 1'b1);
    check("sus_gate_rel", gate, mdl_gate());
    @(posedge clk);
    #1;
    check("sus_update_once", update, 1'b0);
    check("sus_ready_back", event_ready, 1'b1);
`endif

    // Age saturation: lower voices all saturate and tie, so voice 1 loses
    do_reset();
    for (int n = 40; n < 56; n++) do_event(1'b1, 7'(n), 1'b0, 1'b0, 7'd0);
    repeat (250) do_event(1'b1, 7'd55, 1'b0, 1'b0, 7'd0);
    do_event(1'b1, 7'd70, 1'b0, 1'b0, 7'd0);
    check("sat_note1", note1, 7'd70);
    check("sat_note11", note11, 7'd50);

    // Randomized event stream against the model
    do_reset();
    c_on   = 1'b1;
    c_note = 7'd48;
    for (int i = 0; i < 250; i++) begin
      n_on   = ($urandom_range(0, 9) < 7);
      n_note = ($urandom_range(0, 19) == 0) ? 7'($urandom_range(108, 127))
                                            : 7'($urandom_range(36, 63));
      hold   = ($urandom_range(0, 3) == 0);
      do_event(c_on, c_note, hold, n_on, n_note);
      c_on   = n_on;
      c_note = n_note;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
